bamse_irq_ctrl: RTL and testbench
=================================

# bamse_irq_ctrl

Interrupt controller sitting between the bamse peripheral set and the single PacoBlaze3 `interrupt` input. It collects up to eight rising-edge interrupt sources and holds them in a pending register. Arbitration picks one winner, and the block drives the processor interrupt/acknowledge handshake, exposing the winner's index through a port-mapped vector register. Firmware configures and services it through the normal port_id / write_strobe / read_strobe bus, and the bamse top-level I/O mux routes the block's read data.

## Interface
Parameters:
- NSRC, 8, number of interrupt sources (1..8); unused register bits read 0.
- BASE_ADDR, 8'h10, port_id of the first register; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- irq_src  in  NSRC  asynchronous interrupt sources, rising-edge sensitive.
- port_id  in  8  PacoBlaze port address.
- port_in  in  8  PacoBlaze out_port (write data).
- wen  in  1  PacoBlaze write_strobe.
- ren  in  1  PacoBlaze read_strobe (informational only; reads have no side effects).
- port_out  out  8  read data; combinational from port_id, 8'h00 when not addressed.
- hit  out  1  high when port_id is in BASE_ADDR..BASE_ADDR+3 (combinational).
- interrupt  out  1  registered request to PacoBlaze interrupt.
- interrupt_ack  in  1  PacoBlaze interrupt_ack, one-cycle pulse.

## Operation
- Registers:
  - BASE+0 ENABLE (RW): per-source mask.
  - BASE+1 PENDING: read gives pending bits; write is write-1-to-clear.
  - BASE+2 VECTOR (R): bit7 = in service, bits[2:0] = serviced index, other bits 0.
  - BASE+3 EOI (W): any value ends service.
- Source path:
  - Each source passes a 2-flop synchronizer, then an edge register.
  - A synchronized 0->1 transition sets PENDING[i], regardless of ENABLE.
- Set vs. clear: set beats a W1C clear of the same bit in the same cycle.
- Candidates: PENDING & ENABLE.
- Fixed-priority winner: lowest candidate index (see Configuration for the alternative).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ: candidates nonzero. interrupt goes to 1 on that same registered edge.
  - REQ -> SERVICE: on interrupt_ack.
    - Latch the current winner into VECTOR[2:0] and set VECTOR[7].
    - Clear the winner's PENDING bit.
    - interrupt goes to 0.
  - REQ -> IDLE: candidates become zero before the ack (masked or W1C-cleared). interrupt goes to 0 and no vector is latched.
  - SERVICE -> IDLE: on a write to EOI. VECTOR[7] clears and VECTOR[2:0] holds its last value.
  - SERVICE: further edges only accumulate in PENDING; interrupt stays 0.
- Acks outside REQ are ignored. EOI writes outside SERVICE are ignored.
- Reset is asynchronous and may arrive mid-operation:
  - ENABLE, PENDING, VECTOR, synchronizers, edge registers and the round-robin pointer go to 0.
  - State goes to IDLE and interrupt goes to 0.
  - port_out and hit follow port_id combinationally.
- A write takes effect when wen=1 and port_id decodes, on the same clock edge.

## Timing
- Source edge to PENDING set: 3 clk edges after the source rises (2 sync + 1 edge detect).
- PENDING/ENABLE update to interrupt=1: 1 edge (IDLE->REQ registered).
- Source edge to interrupt, best case: 4 edges.
- interrupt_ack edge: interrupt=0, VECTOR and PENDING updated on that same edge. A VECTOR read in the following cycle returns the new value.
- EOI edge -> IDLE. If candidates remain, interrupt reasserts on the next edge, giving a minimum 1-cycle low gap.
- Source pulses shorter than 1 clk may be missed. A source held high sets PENDING only once.

## Configuration
- IRQ_ROUNDROBIN_EN defined:
  - A 3-bit pointer records the last serviced index.
  - The winner is the first candidate searching upward from pointer+1, wrapping modulo NSRC.
  - The pointer updates on interrupt_ack.
- Undefined: fixed lowest-index priority and no pointer logic.

## Test plan
- Reset then idle: ENABLE=0, rise irq_src[3] -> PENDING reads 8'h08 after 3 edges, interrupt stays 0. Write ENABLE=8'h08 -> interrupt=1 next edge.
- Full handshake: ENABLE=8'hFF, pulse src[5] -> interrupt=1. Ack pulse -> interrupt=0, VECTOR=8'h85, PENDING=0. Write EOI -> VECTOR=8'h05, interrupt stays 0.
- Priority: sources 2 and 6 pending, ENABLE=8'hFF -> first ack VECTOR=8'h82; after EOI interrupt reasserts, second ack VECTOR=8'h86.
  - With IRQ_ROUNDROBIN_EN and pointer=2, sources 1 and 6 pending -> VECTOR=8'h86 first.
- Simultaneous set/clear: W1C 8'h01 on the same edge that src[0] sets -> PENDING[0] stays 1. Retract in REQ by writing ENABLE=0 -> interrupt=0, no VECTOR change, ack ignored.
- Reset mid-SERVICE: assert rst low asynchronously -> interrupt, PENDING, ENABLE, VECTOR all 0 before the next clk edge. The bus read of BASE+2 returns 8'h00 with hit=1; port_id 8'h20 gives hit=0, port_out=8'h00.

Source files
------------

// File: rtl/bamse_irq_ctrl.sv
// Eight-source edge-triggered interrupt controller for the PacoBlaze interrupt/ack handshake.
// Define IRQ_ROUNDROBIN_EN for rotating priority; the default is fixed lowest-index priority.
module bamse_irq_ctrl #(
    parameter int          NSRC      = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic [7:0]      port_id,
    input  logic [7:0]      port_in,
    input  logic            wen,
    input  logic            ren,
    output logic [7:0]      port_out,
    output logic            hit,
    output logic            interrupt,
    input  logic            interrupt_ack
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] sync1;
    logic [NSRC-1:0] sync2;
    logic [NSRC-1:0] edge_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_nxt;
    logic [NSRC-1:0] cand;
    logic [7:0]      cand8;
    logic [7:0]      win_oh;
    logic [7:0]      offset;
    logic [2:0]      winner;
    logic [2:0]      k;
    logic [2:0]      vec_idx;
    logic            found;
    logic            ack_take;
    logic            wr_enable;
    logic            wr_pending;
    logic            wr_eoi;
    logic            unused_ren;

    assign unused_ren = ren;

    // Subtracting the base keeps the decode correct even if the window wraps past 8'hFF.
    assign offset     = port_id - BASE_ADDR;
    assign hit        = (offset[7:2] == 6'd0);
    assign wr_enable  = wen && hit && (offset[1:0] == 2'd0);
    assign wr_pending = wen && hit && (offset[1:0] == 2'd1);
    assign wr_eoi     = wen && hit && (offset[1:0] == 2'd3);

    assign rise      = sync2 & ~edge_q;
    assign cand      = pending & enable;
    assign cand8     = 8'(cand);
    assign win_oh    = 8'b1 << winner;
    assign interrupt = (state == REQ);

`ifdef IRQ_ROUNDROBIN_EN
    logic [2:0] ptr;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        k      = '0;
        for (int i = 0; i < NSRC; i++) begin
            k = 3'((int'(ptr) + 1 + i) % NSRC);
            if (!found && cand8[k]) begin
                found  = 1'b1;
                winner = k;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (ack_take)
            ptr <= winner;
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        k      = '0;
        for (int i = 0; i < NSRC; i++) begin
            k = 3'(i);
            if (!found && cand8[k]) begin
                found  = 1'b1;
                winner = k;
            end
        end
    end
`endif

    // Candidates are checked before the ack so a retracted request is never serviced.
    always_comb begin
        state_nxt = state;
        ack_take  = 1'b0;
        case (state)
            IDLE:    if (cand != '0) state_nxt = REQ;
            REQ: begin
                if (cand == '0) begin
                    state_nxt = IDLE;
                end else if (interrupt_ack) begin
                    state_nxt = SERVICE;
                    ack_take  = 1'b1;
                end
            end
            SERVICE: if (wr_eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // New edges are OR-ed in last so they survive a same-cycle clear.
    always_comb begin
        pending_nxt = pending;
        if (wr_pending)
            pending_nxt = pending_nxt & ~port_in[NSRC-1:0];
        if (ack_take)
            pending_nxt = pending_nxt & ~win_oh[NSRC-1:0];
        pending_nxt = pending_nxt | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sync1   <= '0;
            sync2   <= '0;
            edge_q  <= '0;
            enable  <= '0;
            pending <= '0;
            vec_idx <= '0;
        end else begin
            state   <= state_nxt;
            sync1   <= irq_src;
            sync2   <= sync1;
            edge_q  <= sync2;
            pending <= pending_nxt;
            if (wr_enable)
                enable <= port_in[NSRC-1:0];
            if (ack_take)
                vec_idx <= winner;
        end
    end

    always_comb begin
        port_out = 8'h00;
        if (hit) begin
            case (offset[1:0])
                2'd0:    port_out = 8'(enable);
                2'd1:    port_out = 8'(pending);
                2'd2:    port_out = {(state == SERVICE), 4'b0000, vec_idx};
                default: port_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_bamse_irq_ctrl.sv
// Directed bench for bamse_irq_ctrl: handshake, priority, set/clear race, async reset, bus decode.
// Expected vector values switch with IRQ_ROUNDROBIN_EN.
module tb_bamse_irq_ctrl;

    localparam logic [7:0] A_EN   = 8'h10;
    localparam logic [7:0] A_PEND = 8'h11;
    localparam logic [7:0] A_VEC  = 8'h12;
    localparam logic [7:0] A_EOI  = 8'h13;

`ifdef IRQ_ROUNDROBIN_EN
    localparam logic [7:0] P1_FIRST  = 8'h86;
    localparam logic [7:0] P1_PEND   = 8'h04;
    localparam logic [7:0] P1_SECOND = 8'h82;
    localparam logic [7:0] P2_FIRST  = 8'h86;
    localparam logic [7:0] P2_PEND   = 8'h02;
    localparam logic [7:0] P2_SECOND = 8'h81;
`else
    localparam logic [7:0] P1_FIRST  = 8'h82;
    localparam logic [7:0] P1_PEND   = 8'h40;
    localparam logic [7:0] P1_SECOND = 8'h86;
    localparam logic [7:0] P2_FIRST  = 8'h81;
    localparam logic [7:0] P2_PEND   = 8'h40;
    localparam logic [7:0] P2_SECOND = 8'h86;
`endif

    typedef struct {
        logic [7:0] addr;
        logic       exp_hit;
        logic [7:0] exp_data;
    } dec_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irq_src = 8'h00;
    logic [7:0] port_id = 8'h00;
    logic [7:0] port_in = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [7:0] port_out;
    logic       hit;
    logic       interrupt;

    int checks   = 0;
    int failures = 0;

    dec_vec_t vecs [8];

    bamse_irq_ctrl #(.NSRC(8), .BASE_ADDR(8'h10)) dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .port_in       (port_in),
        .wen           (wen),
        .ren           (ren),
        .port_out      (port_out),
        .hit           (hit),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reg(input string name, input logic [7:0] addr, input logic [7:0] exp);
        port_id = addr;
        ren     = 1'b1;
        #1;
        check_output(name, port_out, exp);
        ren     = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic check_int(input string name, input logic exp);
        check_output(name, {7'b0, interrupt}, {7'b0, exp});
    endtask

    task automatic apply_stimulus(input logic [7:0] addr, input logic [7:0] data);
        port_id = addr;
        port_in = data;
        wen     = 1'b1;
        cyc(1);
        wen     = 1'b0;
        port_id = 8'h00;
    endtask

    task automatic pulse_ack();
        interrupt_ack = 1'b1;
        cyc(1);
        interrupt_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{8'h10, 1'b1, 8'hA5};
        vecs[1] = '{8'h11, 1'b1, 8'h00};
        vecs[2] = '{8'h12, 1'b1, 8'h00};
        vecs[3] = '{8'h13, 1'b1, 8'h00};
        vecs[4] = '{8'h0F, 1'b0, 8'h00};
        vecs[5] = '{8'h14, 1'b0, 8'h00};
        vecs[6] = '{8'h20, 1'b0, 8'h00};
        vecs[7] = '{8'h90, 1'b0, 8'h00};

        cyc(3);
        check_int("int_in_reset", 1'b0);
        rst = 1'b1;
        cyc(1);
        check_reg("rst_enable", A_EN, 8'h00);
        check_reg("rst_pending", A_PEND, 8'h00);
        check_reg("rst_vector", A_VEC, 8'h00);
        check_int("rst_int", 1'b0);

        // Masked source latches in PENDING exactly three edges after it rises.
        irq_src = 8'h08;
        cyc(2);
        check_reg("pend_after2", A_PEND, 8'h00);
        cyc(1);
        check_reg("pend_after3", A_PEND, 8'h08);
        check_int("masked_int", 1'b0);
        cyc(2);
        check_int("masked_int_later", 1'b0);
        apply_stimulus(A_EN, 8'h08);
        check_int("int_on_en_edge", 1'b0);
        cyc(1);
        check_int("int_after_en", 1'b1);
        pulse_ack();
        check_int("t1_ack_int", 1'b0);
        check_reg("t1_ack_vec", A_VEC, 8'h83);
        check_reg("t1_ack_pend", A_PEND, 8'h00);
        cyc(3);
        check_reg("held_high_once", A_PEND, 8'h00);
        apply_stimulus(A_EOI, 8'h5A);
        check_reg("t1_eoi_vec", A_VEC, 8'h03);
        check_int("t1_eoi_int", 1'b0);
        irq_src = 8'h00;

        // One-cycle pulse on source 5 with everything enabled.
        apply_stimulus(A_EN, 8'hFF);
        irq_src = 8'h20;
        cyc(1);
        irq_src = 8'h00;
        cyc(2);
        check_int("t2_int_edge3", 1'b0);
        check_reg("t2_pend", A_PEND, 8'h20);
        cyc(1);
        check_int("t2_int_edge4", 1'b1);
        pulse_ack();
        check_int("t2_ack_int", 1'b0);
        check_reg("t2_ack_vec", A_VEC, 8'h85);
        check_reg("t2_ack_pend", A_PEND, 8'h00);
        apply_stimulus(A_EOI, 8'h00);
        check_reg("t2_eoi_vec", A_VEC, 8'h05);
        cyc(1);
        check_int("t2_eoi_int", 1'b0);

        // Sources 2 and 6 together, then serviced back to back.
        irq_src = 8'h44;
        cyc(1);
        irq_src = 8'h00;
        cyc(3);
        check_int("p1_int", 1'b1);
        pulse_ack();
        check_reg("p1_vec1", A_VEC, P1_FIRST);
        check_reg("p1_pend", A_PEND, P1_PEND);
        check_int("p1_ack_int", 1'b0);
        apply_stimulus(A_EOI, 8'h00);
        check_reg("p1_eoi_vec", A_VEC, P1_FIRST & 8'h7F);
        check_int("p1_gap", 1'b0);
        cyc(1);
        check_int("p1_reassert", 1'b1);
        pulse_ack();
        check_reg("p1_vec2", A_VEC, P1_SECOND);
        check_reg("p1_pend2", A_PEND, 8'h00);
        apply_stimulus(A_EOI, 8'h00);

        // Sources 1 and 6 after source 2 was last serviced.
        irq_src = 8'h42;
        cyc(1);
        irq_src = 8'h00;
        cyc(3);
        check_int("p2_int", 1'b1);
        pulse_ack();
        check_reg("p2_vec1", A_VEC, P2_FIRST);
        check_reg("p2_pend", A_PEND, P2_PEND);
        apply_stimulus(A_EOI, 8'h00);
        cyc(1);
        check_int("p2_reassert", 1'b1);
        pulse_ack();
        check_reg("p2_vec2", A_VEC, P2_SECOND);
        apply_stimulus(A_EOI, 8'h00);
        check_reg("p2_eoi_vec", A_VEC, P2_SECOND & 8'h7F);

        // W1C on the same edge that sets PENDING[0]; then retract the request.
        apply_stimulus(A_EN, 8'h01);
        irq_src = 8'h01;
        cyc(2);
        apply_stimulus(A_PEND, 8'h01);
        check_reg("set_beats_clr", A_PEND, 8'h01);
        check_int("sc_int_low", 1'b0);
        cyc(1);
        check_int("sc_int_high", 1'b1);
        apply_stimulus(A_EN, 8'h00);
        cyc(1);
        check_int("retract_int", 1'b0);
        check_reg("retract_vec", A_VEC, P2_SECOND & 8'h7F);
        pulse_ack();
        check_int("stray_ack_int", 1'b0);
        check_reg("stray_ack_vec", A_VEC, P2_SECOND & 8'h7F);
        check_reg("stray_ack_pend", A_PEND, 8'h01);
        apply_stimulus(A_EOI, 8'h00);
        check_reg("stray_eoi_vec", A_VEC, P2_SECOND & 8'h7F);

        // Enter SERVICE, accumulate another edge, then reset between clock edges.
        apply_stimulus(A_EN, 8'hFF);
        cyc(1);
        check_int("t5_int", 1'b1);
        pulse_ack();
        check_reg("t5_vec", A_VEC, 8'h80);
        check_reg("t5_pend0", A_PEND, 8'h00);
        irq_src = 8'h11;
        cyc(3);
        check_reg("t5_accum", A_PEND, 8'h10);
        check_int("t5_svc_int", 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_int("ar_int", 1'b0);
        check_reg("ar_pend", A_PEND, 8'h00);
        check_reg("ar_enable", A_EN, 8'h00);
        port_id = A_VEC;
        #1;
        check_output("ar_vec_hit", {7'b0, hit}, 8'h01);
        check_output("ar_vec_data", port_out, 8'h00);
        port_id = 8'h20;
        #1;
        check_output("ar_miss_hit", {7'b0, hit}, 8'h00);
        check_output("ar_miss_data", port_out, 8'h00);
        port_id = 8'h00;
        irq_src = 8'h00;
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // Bus decode across and around the register window.
        apply_stimulus(A_EN, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            port_id = vecs[i].addr;
            #1;
            check_output($sformatf("dec_hit_%h", vecs[i].addr), {7'b0, hit}, {7'b0, vecs[i].exp_hit});
            check_output($sformatf("dec_data_%h", vecs[i].addr), port_out, vecs[i].exp_data);
        end
        port_id = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
